// File: rtl/if_program_loader_pkg.sv
// rtl/if_program_loader_pkg.sv - shared command, response and state definitions for the program loader
package if_program_loader_pkg;

    localparam int          WORD_SIZE_IN_BYTES = 4;
    localparam logic [31:0] INSTRUCTION_HALT   = 32'hFFFF_FFFF;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam logic [7:0] RSP_LOAD_OK  = 8'hA0;
    localparam logic [7:0] RSP_STEP     = 8'hA1;
    localparam logic [7:0] RSP_END      = 8'hA2;
    localparam logic [7:0] RSP_MEM_FULL = 8'hE1;
    localparam logic [7:0] RSP_EMPTY    = 8'hE2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/if_program_loader_byte_to_word_assembler.sv
// rtl/if_program_loader_byte_to_word_assembler.sv - MSB-first byte shifter with byte counter and word-ready flag
module if_program_loader_byte_to_word_assembler #(
    parameter int WORD_SIZE_IN_BYTES = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_clear,
    input  logic                            i_push,
    input  logic [7:0]                      i_byte,
    output logic [8*WORD_SIZE_IN_BYTES-1:0] o_word,
    output logic                            o_word_ready
);

    localparam int BUS_SIZE = 8 * WORD_SIZE_IN_BYTES;
    localparam int CW       = $clog2(WORD_SIZE_IN_BYTES + 1);

    logic [CW-1:0] byte_count;

    // Clear only restarts the count; the last word stays visible on o_word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_count   <= '0;
            o_word       <= '0;
            o_word_ready <= 1'b0;
        end else if (i_clear) begin
            byte_count   <= '0;
            o_word_ready <= 1'b0;
        end else if (i_push) begin
            o_word <= {o_word[BUS_SIZE-9:0], i_byte};
            if (byte_count == CW'(WORD_SIZE_IN_BYTES - 1)) begin
                byte_count   <= '0;
                o_word_ready <= 1'b1;
            end else begin
                byte_count <= byte_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_program_loader.sv
// rtl/if_program_loader.sv - host command FSM that loads instruction memory and sequences run/step
module if_program_loader
    import if_program_loader_pkg::*;
#(
    parameter int                            WORD_SIZE_IN_BYTES = if_program_loader_pkg::WORD_SIZE_IN_BYTES,
    parameter logic [8*WORD_SIZE_IN_BYTES-1:0] HALT_INSTRUCTION = INSTRUCTION_HALT
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_rx_valid,
    input  logic [7:0]                      i_rx_data,
    output logic                            o_rx_pop,
    input  logic                            i_tx_busy,
    output logic                            o_tx_start,
    output logic [7:0]                      o_tx_data,
    input  logic                            i_full_mem,
    input  logic                            i_empty_mem,
    input  logic                            i_end_program,
    output logic                            o_write_mem,
    output logic [8*WORD_SIZE_IN_BYTES-1:0] o_instruction,
    output logic                            o_start,
    output logic                            o_enable,
    output logic [2:0]                      o_state
);

    localparam int BUS_SIZE = 8 * WORD_SIZE_IN_BYTES;

    state_t              state, state_next;
    logic                started, started_next;
    logic [7:0]          resp_code, resp_code_next;
    logic                asm_clear, asm_push;
    logic [BUS_SIZE-1:0] word;
    logic                word_ready;

    if_program_loader_byte_to_word_assembler #(
        .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
    ) u_assembler (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (asm_clear),
        .i_push      (asm_push),
        .i_byte      (i_rx_data),
        .o_word      (word),
        .o_word_ready(word_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            started   <= 1'b0;
            resp_code <= 8'h00;
        end else begin
            state     <= state_next;
            started   <= started_next;
            resp_code <= resp_code_next;
        end
    end

    // Strobes are combinational from state; reset masks them so every output reads 0.
    always_comb begin
        state_next     = state;
        started_next   = started;
        resp_code_next = resp_code;
        o_rx_pop       = 1'b0;
        asm_push       = 1'b0;
        asm_clear      = 1'b0;
        o_write_mem    = 1'b0;
        o_start        = 1'b0;
        o_enable       = 1'b0;
        o_tx_start     = 1'b0;
        if (!i_reset) begin
            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        o_rx_pop = 1'b1;
                        case (i_rx_data)
                            CMD_LOAD: begin
                                state_next = ST_LOAD;
                                asm_clear  = 1'b1;
                            end
                            CMD_RUN:  state_next = ST_RUN;
                            CMD_STEP: state_next = ST_STEP;
                            default:  state_next = ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (word_ready) begin
                        state_next = ST_WRITE;
                    end else if (i_rx_valid) begin
                        o_rx_pop = 1'b1;
                        asm_push = 1'b1;
                    end
                end
                ST_WRITE: begin
                    asm_clear = 1'b1;
                    if (i_full_mem) begin
                        resp_code_next = RSP_MEM_FULL;
                        state_next     = ST_RESP;
                    end else begin
                        o_write_mem = 1'b1;
                        if (word == HALT_INSTRUCTION) begin
                            resp_code_next = RSP_LOAD_OK;
                            started_next   = 1'b0;
                            state_next     = ST_RESP;
                        end else begin
                            state_next = ST_LOAD;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_empty_mem) begin
                        resp_code_next = RSP_EMPTY;
                        state_next     = ST_RESP;
                    end else if (i_end_program) begin
                        resp_code_next = RSP_END;
                        state_next     = ST_RESP;
                    end else begin
                        o_enable = 1'b1;
                        if (!started) begin
                            o_start      = 1'b1;
                            started_next = 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    state_next = ST_RESP;
                    if (i_empty_mem) begin
                        resp_code_next = RSP_EMPTY;
                    end else if (i_end_program) begin
                        resp_code_next = RSP_END;
                    end else begin
                        resp_code_next = RSP_STEP;
                        o_enable       = 1'b1;
                        if (!started) begin
                            o_start      = 1'b1;
                            started_next = 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (!i_tx_busy) begin
                        o_tx_start = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign o_tx_data     = resp_code;
    assign o_instruction = word;
    assign o_state       = state;

endmodule

// File: tb/tb_if_program_loader.sv
// tb/tb_if_program_loader.sv - randomized self-checking bench for if_program_loader
module tb_if_program_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid, rx_pop, tx_busy, tx_start;
    logic [7:0]  rx_data, tx_data;
    logic        full_mem, empty_mem, end_program;
    logic        write_mem, start, enable;
    logic [31:0] instruction;
    logic [2:0]  state;

    always #5 clk = ~clk;

    if_program_loader dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_rx_pop     (rx_pop),
        .i_tx_busy    (tx_busy),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .i_full_mem   (full_mem),
        .i_empty_mem  (empty_mem),
        .i_end_program(end_program),
        .o_write_mem  (write_mem),
        .o_instruction(instruction),
        .o_start      (start),
        .o_enable     (enable),
        .o_state      (state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Environment: RX FIFO, instruction memory occupancy, pipeline halt and TX busy.
    logic [7:0]  rx_q[$];
    logic [31:0] wr_log[$];
    logic [7:0]  tx_log[$];
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int  start_cnt = 0, enable_cnt = 0, cycle = 0;
    int  mem_words = 0, full_limit = 1000, enables_seen = 0, halt_at = 1000;
    int  busy_left = 0, gap_pct = 0, busy_drop_cycle = 0, tx_cycle = 0;
    int  protocol_errs = 0;
    bit  pop_pending = 1'b0;
    bit  model_started = 1'b0;

    initial begin
        rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        full_mem = 1'b0; empty_mem = 1'b1; end_program = 1'b0;
    end

    always @(negedge clk) begin
        if (pop_pending && rx_q.size() > 0) rx_q.delete(0);
        rx_valid    = (rx_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        rx_data     = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        tx_busy     = busy_left > 0;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) busy_drop_cycle = cycle + 1;
        end
        end_program = enables_seen >= halt_at;
        empty_mem   = mem_words == 0;
        full_mem    = mem_words >= full_limit;
        #1;
        if (rx_pop && !rx_valid) protocol_errs++;
        if (tx_start && tx_busy) protocol_errs++;
        if (!reset) begin
            if (write_mem) begin wr_log.push_back(instruction); mem_words++; end
            if (tx_start) begin tx_log.push_back(tx_data); tx_cycle = cycle; end
            if (start) start_cnt++;
            if (enable) begin enable_cnt++; enables_seen++; end
        end
        pop_pending = rx_pop && !reset;
        cycle++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) rx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'h4C || b == 8'h43 || b == 8'h53) b = 8'h00;
            rx_q.push_back(b);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    task automatic clear_logs();
        wr_log.delete(); tx_log.delete(); exp_wr.delete(); exp_tx.delete();
        start_cnt = 0; enable_cnt = 0;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int budget = 2000;
        while (tx_log.size() < n && budget > 0) begin
            tick(1);
            budget--;
        end
        check({tag, "_timeout"}, (budget > 0) ? 32'd1 : 32'd0, 32'd1);
        tick(3);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
        check({tag, "_ntx"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), {24'h0, tx_log[i]}, {24'h0, exp_tx[i]});
    endtask

    // A program is a list of words terminated by HALT; HALT is written too.
    task automatic load_program(input string tag, input int nwords);
        logic [31:0] w;
        clear_logs();
        halt_at = 1000;
        push_garbage($urandom_range(2));
        rx_q.push_back(8'h4C);
        for (int i = 0; i < nwords; i++) begin
            w = rand_word();
            push_word(w);
            exp_wr.push_back(w);
        end
        push_word(HALT);
        exp_wr.push_back(HALT);
        exp_tx.push_back(8'hA0);
        model_started = 1'b0;
        wait_tx(tag, 1);
        compare_logs(tag);
    endtask

    task automatic run_program(input string tag, input int length);
        clear_logs();
        enables_seen = 0;
        halt_at = length;
        rx_q.push_back(8'h43);
        exp_tx.push_back(8'hA2);
        wait_tx(tag, 1);
        compare_logs(tag);
        check({tag, "_start"}, start_cnt, model_started ? 0 : 1);
        check({tag, "_enable"}, enable_cnt, length);
        model_started = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        tick(3);
        check("rst_write", write_mem, 0);
        check("rst_instr", instruction, 0);
        check("rst_start", start, 0);
        check("rst_enable", enable, 0);
        check("rst_txstart", tx_start, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_pop", rx_pop, 0);
        check("rst_state", state, 0);
        reset = 1'b0;
        tick(2);

        // reset in the middle of a word
        clear_logs();
        rx_q.push_back(8'h4C); rx_q.push_back(8'h12); rx_q.push_back(8'h34);
        tick(6);
        check("midload_state", state, 1);
        reset = 1'b1;
        tick(1);
        check("midrst_state", state, 0);
        check("midrst_instr", instruction, 0);
        check("midrst_enable", enable, 0);
        check("midrst_write", write_mem, 0);
        rx_q.delete();
        tick(1);
        reset = 1'b0;
        tick(1);
        w = rand_word();
        rx_q.push_back(8'h4C);
        push_word(w);
        push_word(HALT);
        exp_wr.push_back(w); exp_wr.push_back(HALT); exp_tx.push_back(8'hA0);
        model_started = 1'b0;
        wait_tx("fresh", 1);
        compare_logs("fresh");

        // fixed program with RX gaps and leading junk
        gap_pct = 30;
        clear_logs();
        push_garbage(3);
        rx_q.push_back(8'h4C);
        push_word(32'h0000_0020); push_word(32'h0000_0021); push_word(HALT);
        exp_wr.push_back(32'h0000_0020); exp_wr.push_back(32'h0000_0021); exp_wr.push_back(HALT);
        exp_tx.push_back(8'hA0);
        wait_tx("fixed", 1);
        compare_logs("fixed");
        gap_pct = 0;

        run_program("run10", 10);

        // run again after end: end wins, nothing launched
        run_program("rerun", 0);

        for (int k = 0; k < 3; k++) begin
            gap_pct = $urandom_range(40);
            load_program($sformatf("rload%0d", k), $urandom_range(1, 4));
            gap_pct = 0;
            run_program($sformatf("rrun%0d", k), $urandom_range(1, 20));
        end

        // single-step until the program ends
        load_program("sload", 2);
        clear_logs();
        enables_seen = 0;
        halt_at = 3;
        repeat (4) rx_q.push_back(8'h53);
        exp_tx.push_back(8'hA1); exp_tx.push_back(8'hA1); exp_tx.push_back(8'hA1); exp_tx.push_back(8'hA2);
        wait_tx("step", 4);
        compare_logs("step");
        check("step_start", start_cnt, 1);
        check("step_enable", enable_cnt, 3);

        // memory fills after the first word
        clear_logs();
        halt_at = 1000;
        full_limit = mem_words + 1;
        w = rand_word();
        rx_q.push_back(8'h4C);
        push_word(w);
        push_word(rand_word());
        exp_wr.push_back(w); exp_tx.push_back(8'hE1);
        wait_tx("full", 1);
        compare_logs("full");
        check("full_state", state, 0);
        full_limit = 1000;

        // empty memory with TX held busy
        clear_logs();
        mem_words = 0;
        busy_left = 5;
        rx_q.push_back(8'h43);
        exp_tx.push_back(8'hE2);
        wait_tx("empty", 1);
        compare_logs("empty");
        check("empty_start", start_cnt, 0);
        check("empty_enable", enable_cnt, 0);
        check("empty_txcycle", tx_cycle, busy_drop_cycle);

        clear_logs();
        rx_q.push_back(8'h53);
        exp_tx.push_back(8'hE2);
        wait_tx("estep", 1);
        compare_logs("estep");
        check("estep_enable", enable_cnt, 0);

        check("protocol", protocol_errs, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
